// File: rtl/vector_sequencer.sv
// vector_sequencer: walks the elements of one DOT/MUV/LDV/STV vector instruction
//   clk, reset (async, active-low)
//   start, isDot, MemWriteV, RegWriteV, RegWriteVV : instruction accept and op selects
//   va_elem, vb_elem : source elements at elem_idx
//   mem_ready        : memory accepts/returns the current element
//   busy             : stall request to the pipeline
//   elem_idx         : current element index
//   mem_req, mem_we, vreg_we : per-element strobes
//   dot_result, dot_valid    : DOT sum and its one-cycle valid
//   done             : one-cycle completion pulse
module vector_sequencer #(
  parameter int VLEN = 8,
  parameter int EW   = 8,
  parameter int IDXW = 3,
  parameter int ACCW = 2*EW+IDXW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            isDot,
  input  logic            MemWriteV,
  input  logic            RegWriteV,
  input  logic            RegWriteVV,
  input  logic [EW-1:0]   va_elem,
  input  logic [EW-1:0]   vb_elem,
  input  logic            mem_ready,
  output logic            busy,
  output logic [IDXW-1:0] elem_idx,
  output logic            mem_req,
  output logic            mem_we,
  output logic            vreg_we,
  output logic [ACCW-1:0] dot_result,
  output logic            dot_valid,
  output logic            done
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_MEM, S_DONE} state_t;
  typedef enum logic [1:0] {OP_DOT, OP_STV, OP_LDV, OP_MUV} op_t;
  state_t state_q, state_d;
  op_t op_q, op_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [ACCW-1:0] acc_q, acc_d, res_q, res_d, prod;
  logic any_sel, last;
  assign any_sel = isDot | MemWriteV | RegWriteV | RegWriteVV;
  assign last = idx_q == IDXW'(VLEN-1);
  assign prod = ACCW'(va_elem) * ACCW'(vb_elem);
  assign elem_idx = idx_q;
  assign dot_result = res_q;
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    idx_d = idx_q;
    acc_d = acc_q;
    res_d = res_q;
    busy = state_q != S_IDLE;
    mem_req = 1'b0;
    mem_we = 1'b0;
    vreg_we = 1'b0;
    dot_valid = 1'b0;
    done = 1'b0;
    case (state_q)
      S_IDLE: if (start && any_sel) begin
        busy = 1'b1;
        op_d = isDot ? OP_DOT : MemWriteV ? OP_STV : RegWriteV ? OP_LDV : OP_MUV;
        idx_d = '0;
        acc_d = '0;
        state_d = (op_d == OP_DOT || op_d == OP_MUV) ? S_RUN : S_MEM;
      end
      S_RUN: begin
        if (op_q == OP_DOT) acc_d = acc_q + prod;
        vreg_we = op_q == OP_MUV;
        if (last) state_d = S_DONE;
        else idx_d = idx_q + 1'b1;
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we = op_q == OP_STV;
        if (mem_ready) begin
          vreg_we = op_q == OP_LDV;
          if (last) state_d = S_DONE;
          else idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        done = 1'b1;
        dot_valid = op_q == OP_DOT;
        state_d = S_IDLE;
        idx_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
    // Capture the final sum on entry to DONE so it is visible alongside dot_valid
    if (state_d == S_DONE && state_q != S_DONE && op_q == OP_DOT) res_d = acc_d;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q <= OP_DOT;
      idx_q <= '0;
      acc_q <= '0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      idx_q <= idx_d;
      acc_q <= acc_d;
      res_q <= res_d;
    end
  end
endmodule

// File: doc/vector_sequencer.md
Name:
vector_sequencer

Overview:
- Multi-cycle sequencer for the vector instructions decoded by Control_Unit (DOT, MUV, LDV, STV).
- Accepts one vector instruction from decode, walks element index 0..VLEN-1, and issues per-element register-write, memory-request and accumulate strobes.
- Holds the pipeline stalled through `busy` until the instruction completes.
- DOT produces a scalar accumulated result for writeback to the scalar register file.

Parameters:
- VLEN, 8: elements per vector; must be a power of two.
- EW, 8: element width in bits.
- IDXW, 3: element index width; equals log2(VLEN).
- ACCW, 2*EW+IDXW (19): DOT accumulator and result width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  decode stage presents a valid vector instruction.
- isDot  in  1  DOT operation select.
- MemWriteV  in  1  STV operation select.
- RegWriteV  in  1  LDV operation select.
- RegWriteVV  in  1  MUV operation select.
- va_elem  in  EW  element elem_idx of source vector A.
- vb_elem  in  EW  element elem_idx of source vector B.
- mem_ready  in  1  data memory accepts or returns the current element this cycle.
- busy  out  1  pipeline stall request.
- elem_idx  out  IDXW  current element index.
- mem_req  out  1  element memory request.
- mem_we  out  1  element memory write (STV).
- vreg_we  out  1  vector register element write (LDV/MUV).
- dot_result  out  ACCW  last completed DOT sum.
- dot_valid  out  1  dot_result is new this cycle.
- done  out  1  instruction complete, 1-cycle pulse.

Behaviour:
- **States:** IDLE, RUN, MEM, DONE.
- **Reset (reset=0, async):** state=IDLE, elem_idx=0, acc=0, dot_result=0, latched op cleared. busy, mem_req, mem_we, vreg_we, dot_valid and done are all 0.
- **Op decode at start, priority order:** isDot > MemWriteV > RegWriteV > RegWriteVV. If start=1 and no select is set, start is ignored and state stays IDLE.
- **busy (combinational):** busy = (state!=IDLE) | (state==IDLE & start & any select). Decode therefore stalls in the same cycle the instruction is accepted.
- **IDLE → RUN or MEM:**
  - On an accepted start: latch op, elem_idx←0, acc←0.
  - DOT/MUV → RUN. LDV/STV → MEM.
- **RUN:** processes one element per cycle.
  - DOT: acc ← acc + va_elem*vb_elem, unsigned, zero-extended to ACCW. Overflow is impossible by construction of ACCW.
  - MUV: vreg_we=1.
  - If elem_idx==VLEN-1 → DONE; otherwise elem_idx+1.
  - mem_ready is ignored in RUN.
- **MEM:**
  - mem_req=1 every cycle; mem_we=1 for STV.
  - elem_idx holds stable until mem_ready=1.
  - On the mem_ready cycle: LDV asserts vreg_we=1. Then advance elem_idx, or go to DONE if elem_idx==VLEN-1.
  - With mem_ready stuck at 0, the block waits indefinitely; there is no timeout.
- **DONE:** lasts exactly 1 cycle.
  - done=1 and busy=1. For DOT: dot_result←acc and dot_valid=1.
  - Then → IDLE with elem_idx←0.
  - dot_result holds its value until the next DOT completes or reset.
- **Latency, with start accepted in cycle 0:**
  - DOT/MUV: element k is processed in cycle k+1; done in cycle VLEN+1.
  - LDV/STV: done in the cycle after the VLEN-th mem_ready.
- **Boundaries:**
  - start while state!=IDLE is ignored; the op latch is not disturbed.
  - Select inputs changing mid-operation have no effect.
  - Reset mid-operation aborts immediately: no further vreg_we or mem_req, and acc/dot_result return to 0.
  - elem_idx never wraps past VLEN-1 inside an operation.

Test Plan:
1. **DOT:** va_elem=3 for all elements, vb_elem=idx+1, start+isDot in cycle 0 → busy in cycles 0–9, dot_valid and done in cycle 9, dot_result=108.
2. **DOT saturation:** va=vb=255 for all elements → dot_result=520200 with no overflow. A following DOT with zeros → dot_result=0.
3. **LDV with slow memory:** mem_ready on alternate cycles → elem_idx holds across wait cycles, exactly 8 vreg_we pulses with idx 0..7, done one cycle after the 8th ready, mem_we=0 throughout.
4. **STV and MUV:** STV with mem_ready=1 constantly → mem_req and mem_we high in cycles 1–8, done in cycle 9. MUV → vreg_we in cycles 1–8.
5. **Priority and ignore:**
   - isDot and MemWriteV both set → DOT runs.
   - start with no select → busy=0 and no state change.
   - start asserted in cycle 3 of a DOT → ignored.
6. **Reset mid-operation:** reset asserted while a DOT is at elem_idx=4 → all outputs 0 immediately, dot_result=0, no done. A new DOT after release runs normally.
